// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable synchronized
// lock, releases the system reset after a delay, and re-acquires on lock loss.
// A bounded number of acquisition timeouts latches a sticky failure.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES     = 10,
  parameter int unsigned LOCK_TIMEOUT       = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RELEASE_DELAY      = 16,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic       refclk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  output logic       pll_rst_o,
  output logic       sys_rst_o,
  output logic       ready_o,
  output logic       lock_lost_o,
  output logic [3:0] retry_count_o,
  output logic       fail_o
);

  localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CD  = (LOCK_STABLE_CYCLES > RELEASE_DELAY) ? LOCK_STABLE_CYCLES : RELEASE_DELAY;
  localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned RETRY_W = 4;

  // Terminal counts; the counter only ever reaches (parameter - 1), so no wrap.
  localparam logic [CNT_W-1:0]   ASSERT_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   RELEASE_LAST = CNT_W'(RELEASE_DELAY - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RELEASE,
    ST_RUN,
    ST_FAIL
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               sync1_q, lock_s_q;
  logic               pll_rst_q, sys_rst_q, ready_q, lock_lost_q, fail_q;
  logic               pll_rst_d, sys_rst_d, ready_d, lock_lost_d, fail_d;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_locked_i;
      lock_s_q <= sync1_q;
    end
  end

  // State, shared phase counter and retry counter.
  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  // Next-state logic; output values are decoded from the next state so the
  // registered outputs line up with the state register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;

    unique case (state_q)
      ST_ASSERT: begin
        // Lock is ignored here: it may be stale from before the PLL reset.
        if (cnt_q == ASSERT_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = '0;
          if (retry_q == RETRY_MAX) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_ASSERT;
            retry_d = retry_q + RETRY_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        // A drop on the final count still takes the drop path.
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!lock_s_q) begin
          state_d     = ST_ASSERT;
          cnt_d       = '0;
          retry_d     = '0;
          lock_lost_d = 1'b1;
        end else if (cnt_q == RELEASE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s_q) begin
          state_d     = ST_ASSERT;
          cnt_d       = '0;
          retry_d     = '0;
          lock_lost_d = 1'b1;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
      end
    endcase

    pll_rst_d = (state_d == ST_ASSERT) || (state_d == ST_FAIL);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fail_d    = (state_d == ST_FAIL);
  end

  // Registered outputs.
  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_rst_o     = pll_rst_q;
  assign sys_rst_o     = sys_rst_q;
  assign ready_o       = ready_q;
  assign lock_lost_o   = lock_lost_q;
  assign retry_count_o = retry_q;
  assign fail_o        = fail_q;

endmodule
